// File: rtl/fft_input_deserializer.sv
// Packs N streamed sample words into one parallel frame for fft_fp and holds it until fft_done.
// Optional BIT_REVERSE_IN_EN: sample k lands in slot bitrev(k) instead of slot k.
//
// state   | meaning
// --------+---------------------------------------------------------------
// COLLECT | accepting beats into slot cnt, checking frame length
// DRAIN   | long frame seen; discarding beats up to and including in_last
// START   | frame complete; fft_start high for this one cycle
// WAIT    | bus held for fft_fp; leaves on fft_done
module fft_input_deserializer #(
  parameter int N         = 8,
  parameter int WORD_SIZE = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [WORD_SIZE-1:0]   in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  input  logic                   fft_done,
  output logic [N*WORD_SIZE-1:0] par_data,
  output logic                   fft_start,
  output logic                   frame_err
);

  localparam int             CW      = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(N - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    START   = 2'd2,
    WAIT    = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] wr_slot;
  logic          beat;

  function automatic logic [CW-1:0] slot_of(input logic [CW-1:0] k);
`ifdef BIT_REVERSE_IN_EN
    logic [CW-1:0] r;
    for (int i = 0; i < CW; i++) r[i] = k[CW-1-i];
    return r;
`else
    return k;
`endif
  endfunction

  assign wr_slot = slot_of(cnt);
  assign beat    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= COLLECT;
      cnt       <= '0;
      par_data  <= '0;
      in_ready  <= 1'b0;
      fft_start <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      fft_start <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        COLLECT: begin
          in_ready <= 1'b1;
          if (beat) begin
            // Every accepted beat lands in the bus, even one that turns out malformed.
            par_data[int'(wr_slot)*WORD_SIZE +: WORD_SIZE] <= in_data;
            if (cnt == CNT_MAX) begin
              cnt <= '0;
              if (in_last) begin
                state     <= START;
                fft_start <= 1'b1;
                in_ready  <= 1'b0;
              end else begin
                state     <= DRAIN;
                frame_err <= 1'b1;
              end
            end else if (in_last) begin
              cnt       <= '0;
              frame_err <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          in_ready <= 1'b1;
          if (beat && in_last) state <= COLLECT;
        end
        START: begin
          in_ready <= 1'b0;
          state    <= WAIT;
        end
        WAIT: begin
          if (fft_done) begin
            state    <= COLLECT;
            in_ready <= 1'b1;
          end else begin
            in_ready <= 1'b0;
          end
        end
        default: begin
          state    <= COLLECT;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_input_deserializer.sv
// Self-checking bench for fft_input_deserializer: expected frames are queued when sent and
// compared against par_data whenever fft_start fires.
module tb_fft_input_deserializer;

  localparam int N = 8;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_last;
  logic           in_ready;
  logic           fft_done;
  logic [N*W-1:0] par_data;
  logic           fft_start;
  logic           frame_err;

  int tests = 0;
  int fails = 0;
  int start_cnt = 0;
  int err_cnt = 0;
  logic [N*W-1:0] exp_q[$];

  fft_input_deserializer #(.N(N), .WORD_SIZE(W)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .fft_done(fft_done),
    .par_data(par_data), .fft_start(fft_start), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  function automatic int tb_slot(input int k);
`ifdef BIT_REVERSE_IN_EN
    int r = 0;
    for (int i = 0; i < $clog2(N); i++) if (((k >> i) & 1) != 0) r |= 1 << ($clog2(N) - 1 - i);
    return r;
`else
    return k;
`endif
  endfunction

  // Scoreboard: every start pulse must match the oldest queued frame.
  always @(negedge clk) begin
    if (fft_start === 1'b1) begin
      logic [N*W-1:0] exp;
      start_cnt++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_start: fft_start seen with no frame queued, par_data=%h", par_data);
      end else begin
        exp = exp_q.pop_front();
        if (par_data !== exp) begin
          fails++;
          $display("FAIL frame_data: got %h expected %h", par_data, exp);
        end
      end
    end
    if (frame_err === 1'b1) err_cnt++;
  end

  task automatic send_beat(input logic [W-1:0] d, input logic l, input int gap);
    int n = 0;
    repeat (gap) begin @(posedge clk); #1; end
    in_data = d; in_last = l; in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL ready_timeout: in_ready=%b required 1 within 50 cycles", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] base, input bit gaps);
    logic [N*W-1:0] exp = '0;
    for (int k = 0; k < N; k++) exp[tb_slot(k)*W +: W] = base + W'(k);
    exp_q.push_back(exp);
    for (int k = 0; k < N; k++) send_beat(base + W'(k), k == N-1, gaps ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic wait_start();
    int n = 0;
    while (fft_start !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
    tests++;
    if (fft_start !== 1'b1) begin
      fails++;
      $display("FAIL start_timeout: fft_start=%b required 1 within 10 cycles", fft_start);
    end
  endtask

  // Entered in the START cycle; checks the hold, then answers with fft_done.
  task automatic finish_frame(input int hold);
    logic [N*W-1:0] held = par_data;
    @(posedge clk); #1;
    for (int i = 0; i < hold; i++) begin
      tests++;
      if (in_ready !== 1'b0 || fft_start !== 1'b0 || par_data !== held) begin
        fails++;
        $display("FAIL wait_hold: cyc %0d in_ready=%b fft_start=%b data_changed=%b required 0/0/0",
                 i, in_ready, fft_start, par_data !== held);
      end
      @(posedge clk); #1;
    end
    fft_done = 1'b1;
    @(posedge clk); #1;
    fft_done = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || par_data !== held) begin
      fails++;
      $display("FAIL done_release: in_ready=%b required 1, data_changed=%b required 0",
               in_ready, par_data !== held);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (par_data !== '0 || in_ready !== 1'b0 || fft_start !== 1'b0 || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: par_data=%h in_ready=%b fft_start=%b frame_err=%b required all 0",
               par_data, in_ready, fft_start, frame_err);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_reset: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_basic_frame();
    send_frame(32'h1, 1'b0);
    tests++;
    if (fft_start !== 1'b1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL start_latency: fft_start=%b in_ready=%b required 1/0", fft_start, in_ready);
    end
    tests++;
    if (par_data[31:0] !== 32'h1 || par_data[255:224] !== 32'h8) begin
      fails++;
      $display("FAIL edge_slots: slot0=%h slot7=%h required 1/8", par_data[31:0], par_data[255:224]);
    end
    finish_frame(2);
  endtask

  task automatic test_gaps();
    int s0 = start_cnt;
    send_frame(32'h1, 1'b1);
    wait_start();
    finish_frame(1);
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (start_cnt - s0 !== 1) begin
      fails++;
      $display("FAIL gap_start_count: got %0d required 1", start_cnt - s0);
    end
  endtask

  task automatic test_short_frame();
    int s0 = start_cnt, e0 = err_cnt;
    for (int k = 0; k < 5; k++) send_beat(32'h50 + W'(k), k == 4, 0);
    tests++;
    if (frame_err !== 1'b1) begin
      fails++;
      $display("FAIL short_err_pulse: frame_err=%b required 1", frame_err);
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (err_cnt - e0 !== 1 || start_cnt - s0 !== 0) begin
      fails++;
      $display("FAIL short_counts: errs=%0d starts=%0d required 1/0", err_cnt - e0, start_cnt - s0);
    end
    send_frame(32'hA0, 1'b0);
    wait_start();
    tests++;
    if (par_data[4*W +: W] !== 32'hA0 + W'(tb_slot(4))) begin
      fails++;
      $display("FAIL short_refill: slot4=%h required %h", par_data[4*W +: W], 32'hA0 + W'(tb_slot(4)));
    end
    finish_frame(0);
  endtask

  task automatic test_long_frame();
    int s0 = start_cnt, e0 = err_cnt;
    for (int k = 0; k < 10; k++) begin
      send_beat(32'h70 + W'(k), k == 9, 0);
      if (k == 7) begin
        tests++;
        if (frame_err !== 1'b1) begin
          fails++;
          $display("FAIL long_err_pulse: frame_err=%b after beat 8 required 1", frame_err);
        end
      end
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (err_cnt - e0 !== 1 || start_cnt - s0 !== 0) begin
      fails++;
      $display("FAIL long_counts: errs=%0d starts=%0d required 1/0", err_cnt - e0, start_cnt - s0);
    end
    send_frame(32'hC0, 1'b1);
    wait_start();
    finish_frame(0);
  endtask

  task automatic test_hold_and_reset();
    int e0;
    send_frame(32'hD0, 1'b0);
    wait_start();
    finish_frame(20);
    e0 = err_cnt;
    for (int k = 0; k < 4; k++) send_beat(32'hE0 + W'(k), 1'b0, 0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (par_data !== '0 || in_ready !== 1'b0 || fft_start !== 1'b0 || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: par_data=%h in_ready=%b fft_start=%b frame_err=%b required all 0",
               par_data, in_ready, fft_start, frame_err);
    end
    reset_n = 1'b1;
    send_frame(32'hF0, 1'b0);
    wait_start();
    finish_frame(0);
    tests++;
    if (err_cnt !== e0) begin
      fails++;
      $display("FAIL reset_silent: frame_err pulses=%0d required 0", err_cnt - e0);
    end
  endtask

  task automatic test_order();
    send_frame(32'h0, 1'b0);
    wait_start();
    tests++;
`ifdef BIT_REVERSE_IN_EN
    if (par_data[1*W +: W] !== 32'd4 || par_data[3*W +: W] !== 32'd6) begin
      fails++;
      $display("FAIL bitrev_order: slot1=%h slot3=%h required 4/6", par_data[1*W +: W], par_data[3*W +: W]);
    end
`else
    if (par_data[1*W +: W] !== 32'd1 || par_data[3*W +: W] !== 32'd3) begin
      fails++;
      $display("FAIL natural_order: slot1=%h slot3=%h required 1/3", par_data[1*W +: W], par_data[3*W +: W]);
    end
`endif
    finish_frame(0);
  endtask

  initial begin
    reset_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; fft_done = 1'b0;
    test_reset();
    test_basic_frame();
    test_gaps();
    test_short_frame();
    test_long_frame();
    test_hold_and_reset();
    test_order();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL frames_pending: %0d queued frames never started, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
